// File: rtl/lifo_stack_ctrl_if.sv
// Bundle of the stack command/status signals and the external RAM port.
// The slave modport is the controller; the master modport is the client plus the RAM.
interface lifo_stack_ctrl_if #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 15
);
  logic                  clear;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  pop_valid;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow_err;
  logic                  underflow_err;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport master (
    output clear, push, pop, push_data, ram_rd_data,
    input  pop_data, pop_valid, full, empty, count, overflow_err, underflow_err,
           ram_we, ram_wr_addr, ram_rd_addr, ram_wr_data
  );

  modport slave (
    input  clear, push, pop, push_data, ram_rd_data,
    output pop_data, pop_valid, full, empty, count, overflow_err, underflow_err,
           ram_we, ram_wr_addr, ram_rd_addr, ram_wr_data
  );
endinterface

// File: rtl/lifo_stack_ctrl.sv
// LIFO stack controller driving an external RAM with registered, read-before-write reads.
// The top of stack lives at address count-1; pop data arrives one cycle after the pop.
module lifo_stack_ctrl #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  lifo_stack_ctrl_if.slave     bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [ADDR_WIDTH-1:0] top_addr;
  logic                  full, empty;
  logic                  push_acc, pop_acc;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == DEPTH);
    top_addr = count_q[ADDR_WIDTH-1:0] - 1'b1;
    // A simultaneous pop frees the top slot, so push is taken even when full.
    push_acc = bus.push & (~full | bus.pop) & ~bus.clear;
    pop_acc  = bus.pop & ~empty & ~bus.clear;

    count_d     = count_q;
    pop_valid_d = pop_acc;
    ovf_d       = ovf_q | (bus.push & ~bus.pop & full);
    unf_d       = unf_q | (bus.pop & empty);
    if (bus.clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (push_acc && !pop_acc) begin
      count_d = count_q + 1'b1;
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_comb begin
    bus.full          = full;
    bus.empty         = empty;
    bus.count         = count_q;
    bus.pop_valid     = pop_valid_q;
    bus.pop_data      = bus.ram_rd_data;
    bus.overflow_err  = ovf_q;
    bus.underflow_err = unf_q;
    bus.ram_we        = push_acc & ~rst;
    bus.ram_wr_data   = bus.push_data;
    bus.ram_wr_addr   = pop_acc ? top_addr : count_q[ADDR_WIDTH-1:0];
    bus.ram_rd_addr   = empty ? '0 : top_addr;
  end

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// Self-checking bench for lifo_stack_ctrl with a 4-deep stack and a behavioural RAM.
module tb_lifo_stack_ctrl;
  localparam int DW    = 9;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  lifo_stack_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  lifo_stack_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    bus.ram_rd_data <= ram[bus.ram_rd_addr];
    if (bus.ram_we) ram[bus.ram_wr_addr] <= bus.ram_wr_data;
  end

  // Reference model: a queue whose back is the stack top.
  logic [DW-1:0] model[$];
  bit            m_ovf, m_unf;
  logic          last_pv;
  logic [DW-1:0] last_pd;

  task automatic model_reset();
    model.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic drive_cycle(input logic c, input logic ph, input logic pp, input logic [DW-1:0] d);
    int            sz;
    logic          exp_we, exp_pv;
    logic [DW-1:0] exp_pd;
    logic [AW-1:0] exp_wa, exp_ra;
    @(negedge clk);
    bus.clear = c; bus.push = ph; bus.pop = pp; bus.push_data = d;
    #1;
    sz     = model.size();
    exp_we = !c && ph && (pp || sz < DEPTH);
    exp_wa = AW'((pp && sz > 0) ? sz - 1 : sz);
    exp_ra = AW'((sz > 0) ? sz - 1 : 0);
    checks++;
    if (bus.ram_we !== exp_we) begin
      failures++; $display("FAIL ram_we got=%b exp=%b", bus.ram_we, exp_we);
    end
    checks++;
    if (bus.ram_rd_addr !== exp_ra) begin
      failures++; $display("FAIL ram_rd_addr got=%0d exp=%0d", bus.ram_rd_addr, exp_ra);
    end
    checks++;
    if (bus.empty !== (sz == 0) || bus.full !== (sz == DEPTH)) begin
      failures++; $display("FAIL flags empty=%b full=%b size=%0d", bus.empty, bus.full, sz);
    end
    if (exp_we) begin
      checks++;
      if (bus.ram_wr_addr !== exp_wa || bus.ram_wr_data !== d) begin
        failures++;
        $display("FAIL ram_write addr=%0d data=%h exp addr=%0d data=%h",
                 bus.ram_wr_addr, bus.ram_wr_data, exp_wa, d);
      end
    end
    exp_pv = 0;
    exp_pd = '0;
    if (c) begin
      model_reset();
    end else if (ph && !pp) begin
      if (sz == DEPTH) m_ovf = 1; else model.push_back(d);
    end else if (pp && !ph) begin
      if (sz == 0) m_unf = 1;
      else begin exp_pd = model.pop_back(); exp_pv = 1; end
    end else if (ph && pp) begin
      if (sz == 0) begin m_unf = 1; model.push_back(d); end
      else begin exp_pd = model[sz-1]; model[sz-1] = d; exp_pv = 1; end
    end
    @(posedge clk);
    #1;
    last_pv = bus.pop_valid;
    last_pd = bus.pop_data;
    checks++;
    if (bus.count !== (AW+1)'(model.size())) begin
      failures++; $display("FAIL count got=%0d exp=%0d", bus.count, model.size());
    end
    checks++;
    if (bus.overflow_err !== m_ovf || bus.underflow_err !== m_unf) begin
      failures++;
      $display("FAIL err_flags ovf=%b unf=%b exp ovf=%b unf=%b",
               bus.overflow_err, bus.underflow_err, m_ovf, m_unf);
    end
    checks++;
    if (bus.pop_valid !== exp_pv) begin
      failures++; $display("FAIL pop_valid got=%b exp=%b", bus.pop_valid, exp_pv);
    end
    if (exp_pv) begin
      checks++;
      if (bus.pop_data !== exp_pd) begin
        failures++; $display("FAIL pop_data got=%h exp=%h", bus.pop_data, exp_pd);
      end
    end
  endtask

  task automatic test_reset();
    bus.clear = 0; bus.push = 1; bus.pop = 0; bus.push_data = 9'h123;
    #12;
    checks++;
    if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.pop_valid !== 1'b0 ||
        bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0 || bus.ram_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_state count=%0d empty=%b full=%b pv=%b ovf=%b unf=%b we=%b",
               bus.count, bus.empty, bus.full, bus.pop_valid, bus.overflow_err,
               bus.underflow_err, bus.ram_we);
    end
    @(negedge clk);
    bus.push = 0;
    rst = 0;
    model_reset();
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] vals [4];
    vals[0] = 9'h011; vals[1] = 9'h022; vals[2] = 9'h033; vals[3] = 9'h044;
    drive_cycle(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) drive_cycle(0, 1, 0, vals[i]);
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 3'd4) begin
      failures++; $display("FAIL fill full=%b count=%0d exp full=1 count=4", bus.full, bus.count);
    end
    for (int i = 3; i >= 0; i--) begin
      drive_cycle(0, 0, 1, '0);
      checks++;
      if (last_pv !== 1'b1 || last_pd !== vals[i]) begin
        failures++; $display("FAIL drain pv=%b data=%h exp=%h", last_pv, last_pd, vals[i]);
      end
    end
    checks++;
    if (bus.empty !== 1'b1) begin
      failures++; $display("FAIL drain_empty got=%b exp=1", bus.empty);
    end
  endtask

  task automatic test_overflow();
    drive_cycle(1, 0, 0, '0);
    drive_cycle(0, 1, 0, 9'h011);
    drive_cycle(0, 1, 0, 9'h022);
    drive_cycle(0, 1, 0, 9'h033);
    drive_cycle(0, 1, 0, 9'h044);
    drive_cycle(0, 1, 0, 9'h1FF);
    checks++;
    if (bus.overflow_err !== 1'b1 || bus.count !== 3'd4) begin
      failures++; $display("FAIL overflow ovf=%b count=%0d exp 1/4", bus.overflow_err, bus.count);
    end
    drive_cycle(0, 0, 1, '0);
    checks++;
    if (last_pv !== 1'b1 || last_pd !== 9'h044) begin
      failures++; $display("FAIL overflow_pop data=%h exp=044", last_pd);
    end
  endtask

  task automatic test_underflow();
    drive_cycle(1, 0, 0, '0);
    drive_cycle(0, 0, 1, '0);
    checks++;
    if (bus.underflow_err !== 1'b1 || last_pv !== 1'b0) begin
      failures++; $display("FAIL underflow unf=%b pv=%b exp 1/0", bus.underflow_err, last_pv);
    end
    drive_cycle(0, 1, 1, 9'h055);
    checks++;
    if (bus.count !== 3'd1 || bus.underflow_err !== 1'b1 || last_pv !== 1'b0) begin
      failures++;
      $display("FAIL underflow_pushpop count=%0d unf=%b pv=%b exp 1/1/0",
               bus.count, bus.underflow_err, last_pv);
    end
    drive_cycle(0, 0, 0, '0);
    drive_cycle(0, 0, 1, '0);
    checks++;
    if (last_pv !== 1'b1 || last_pd !== 9'h055) begin
      failures++; $display("FAIL underflow_pop data=%h exp=055", last_pd);
    end
  endtask

  task automatic test_push_pop();
    drive_cycle(1, 0, 0, '0);
    drive_cycle(0, 1, 0, 9'h011);
    drive_cycle(0, 1, 0, 9'h022);
    drive_cycle(0, 1, 1, 9'h0AA);
    checks++;
    if (last_pv !== 1'b1 || last_pd !== 9'h022 || bus.count !== 3'd2) begin
      failures++;
      $display("FAIL push_pop data=%h count=%0d exp 022/2", last_pd, bus.count);
    end
    drive_cycle(0, 0, 1, '0);
    checks++;
    if (last_pv !== 1'b1 || last_pd !== 9'h0AA) begin
      failures++; $display("FAIL push_pop_later data=%h exp=0aa", last_pd);
    end
  endtask

  task automatic test_clear();
    drive_cycle(1, 0, 0, '0);
    drive_cycle(0, 0, 1, '0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, DW'(9'h100 + i));
    drive_cycle(1, 1, 0, 9'h0EE);
    checks++;
    if (bus.count !== 3'd0 || bus.underflow_err !== 1'b0 || bus.overflow_err !== 1'b0 ||
        bus.pop_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear count=%0d ovf=%b unf=%b pv=%b exp 0/0/0/0",
               bus.count, bus.overflow_err, bus.underflow_err, bus.pop_valid);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 0, 0, '0);
    drive_cycle(0, 1, 0, 9'h0A1);
    drive_cycle(0, 1, 0, 9'h0A2);
    @(negedge clk);
    bus.pop = 1; bus.push = 1; bus.push_data = 9'h0BB;
    #2 rst = 1;
    #1;
    checks++;
    if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.ram_we !== 1'b0) begin
      failures++;
      $display("FAIL async_reset count=%0d empty=%b we=%b exp 0/1/0", bus.count, bus.empty, bus.ram_we);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.pop_valid !== 1'b0 || bus.count !== 3'd0) begin
      failures++; $display("FAIL async_reset_edge pv=%b count=%0d exp 0/0", bus.pop_valid, bus.count);
    end
    @(negedge clk);
    bus.pop = 0; bus.push = 0;
    rst = 0;
    model_reset();
    drive_cycle(0, 1, 0, 9'h0C3);
    drive_cycle(0, 0, 1, '0);
    checks++;
    if (last_pv !== 1'b1 || last_pd !== 9'h0C3) begin
      failures++; $display("FAIL post_reset_pop data=%h exp=0c3", last_pd);
    end
  endtask

  task automatic test_random();
    logic c, ph, pp;
    for (int i = 0; i < 400; i++) begin
      c  = ($urandom_range(0, 39) == 0);
      ph = ($urandom_range(0, 99) < 55);
      pp = ($urandom_range(0, 99) < 45);
      drive_cycle(c, ph, pp, DW'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clear = 0; bus.push = 0; bus.pop = 0; bus.push_data = '0;
    last_pv = 0; last_pd = '0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_push_pop();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lifo_stack_ctrl.md
LIFO_STACK_CTRL -- requirements
Module: lifo_stack_ctrl

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 9: the width of each stack entry.
REQ-002 The block SHALL have the parameter ADDR_WIDTH, default 15: the RAM address width, giving a depth of 2**ADDR_WIDTH.
REQ-003 The block SHALL have: clk  input  1  the single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have: rst  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have: clear  input  1  synchronous empty-stack command.
REQ-006 The block SHALL have: push  input  1  push request.
REQ-007 The block SHALL have: pop  input  1  pop request.
REQ-008 The block SHALL have: push_data  input  DATA_WIDTH  the value to push.
REQ-009 The block SHALL have: pop_data  output  DATA_WIDTH  the popped value; valid only while pop_valid=1.
REQ-010 The block SHALL have: pop_valid  output  1  one-cycle strobe marking pop_data valid.
REQ-011 The block SHALL have: full, empty  output  1 each  stack status flags.
REQ-012 The block SHALL have: count  output  ADDR_WIDTH+1  the number of stored entries.
REQ-013 The block SHALL have: overflow_err, underflow_err  output  1 each  sticky error flags.
REQ-014 The block SHALL have: ram_we  output  1  RAM write enable.
REQ-015 The block SHALL have: ram_wr_addr, ram_rd_addr  output  ADDR_WIDTH each  RAM write and read addresses.
REQ-016 The block SHALL have: ram_wr_data  output  DATA_WIDTH  RAM write data.
REQ-017 The block SHALL have: ram_rd_data  input  DATA_WIDTH  registered RAM read data, valid one clock after the address; read-before-write on an address collision.

Function
REQ-018 The block SHALL drive empty=(count==0) and full=(count==2**ADDR_WIDTH), both combinational from count.
REQ-019 The block SHALL evaluate the request in the following cases: push_acc and pop_acc are the accepted push and pop for the current cycle.
- push only: push_acc=push & ~full.
- pop only: pop_acc=pop & ~empty.
- push & pop & ~empty: both accepted, including when full.
- push & pop & empty: push accepted, pop rejected.
REQ-020 The block SHALL, on push_acc with no pop_acc, write to address count[ADDR_WIDTH-1:0], then increment count by 1.
REQ-021 The block SHALL, on pop_acc with no push_acc, read from address count-1, then decrement count by 1.
REQ-022 The block SHALL, on simultaneous push_acc and pop_acc, read and write address count-1 and leave count unchanged. pop returns the old top value; the new value replaces it.
REQ-023 The block SHALL set ram_we=push_acc and ram_wr_data=push_data, both combinational.
REQ-024 The block SHALL drive ram_rd_addr=count-1 (truncated to ADDR_WIDTH bits) whenever count is non-zero, and 0 otherwise.
REQ-025 The block SHALL register pop_valid from pop_acc, giving a latency of exactly one cycle from the accepted pop to pop_valid=1.
REQ-026 The block SHALL drive pop_data=ram_rd_data directly.
REQ-027 The block SHALL set overflow_err when push & ~pop & full, and hold it until rst or clear; the stack is unchanged.
REQ-028 The block SHALL set underflow_err when pop & empty, including push+pop on an empty stack; it holds until rst or clear.
REQ-029 The block SHALL, when clear=1, set count=0 and clear both error flags, with ram_we=0 and pop_valid=0 on the next cycle. clear has priority over push and pop.
REQ-030 The block SHALL never wrap count past 2**ADDR_WIDTH or below 0.
REQ-031 The block SHALL leave RAM contents uninitialised; an entry is defined only after it is pushed.

Reset
REQ-032 The block SHALL, while rst=1, asynchronously force:
- count=0
- pop_valid=0
- overflow_err=0, underflow_err=0
REQ-033 The block SHALL keep ram_we=0 during reset, so that the RAM sees no write.
REQ-034 The block SHALL drop a pop in flight when rst asserts mid-operation: pop_valid stays 0.
REQ-035 The block SHALL begin accepting requests at the first rising clk edge after rst deasserts.

Verification (ADDR_WIDTH=2, DATA_WIDTH=9, behavioural RAM model)
REQ-036 Push 0x011, 0x022, 0x033, 0x044 -> count=4 and full=1; then pop ×4 -> pop_data 0x044, 0x033, 0x022, 0x011, each one cycle after its pop, ending with empty=1.
REQ-037 At full, push 0x1FF -> overflow_err=1, count stays 4; a following pop returns 0x044.
REQ-038 Empty stack, pop -> underflow_err=1, pop_valid stays 0; push+pop with 0x055 -> count=1, underflow_err=1, and a later pop returns 0x055.
REQ-039 Stack holding 0x011 and 0x022, push+pop with 0x0AA -> pop_data=0x022, count stays 2; a later pop returns 0x0AA.
REQ-040 Push 3 entries, assert clear together with push -> count=0, errors=0, ram_we=0.
REQ-041 Assert rst asynchronously between clock edges during a pop -> count=0 immediately, and pop_valid=0 on the following edge.
